// File: rtl/rp_pio_err_regs_pkg.sv
// Shared types and constants for the Root Port PIO error register block.
// The implemented-bit helper is reused by the register file and by its reset values.
package rp_pio_pkg;

    typedef enum logic [1:0] {
        SPC_CFG = 2'd0,
        SPC_IO  = 2'd1,
        SPC_MEM = 2'd2
    } space_e;

    typedef enum logic [1:0] {
        ERR_UR_CPL = 2'd0,
        ERR_CA_CPL = 2'd1,
        ERR_CTO    = 2'd2
    } err_e;

    localparam int unsigned REG_STATUS = 0;
    localparam int unsigned REG_MASK   = 1;
    localparam int unsigned REG_SEV    = 2;
    localparam int unsigned REG_SYSERR = 3;
    localparam int unsigned REG_PTR    = 4;
    localparam int unsigned REG_LOG0   = 5;

    function automatic logic [31:0] implemented_mask(int unsigned ns, int unsigned ne,
                                                     int unsigned fs);
        logic [31:0] m;
        m = '0;
        for (int unsigned s = 0; s < ns; s++) begin
            for (int unsigned e = 0; e < ne; e++) begin
                if (s * fs + e < 32) m[s * fs + e] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rp_pio_err_regs_if.sv
// Register access bus plus error-event and error-signalling lines of the PIO error block.
interface rp_pio_err_regs_if #(
    parameter int unsigned NUM_SPACES = 3,
    parameter int unsigned NUM_ERR    = 3,
    parameter int unsigned LOG_DW     = 4,
    parameter int unsigned ADDR_W     = 4
);
    localparam int unsigned SW = (NUM_SPACES > 1) ? $clog2(NUM_SPACES) : 1;
    localparam int unsigned TW = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1;

    logic [ADDR_W-1:0]     reg_addr;
    logic                  reg_wr;
    logic [31:0]           reg_wdata;
    logic                  reg_rd;
    logic [31:0]           reg_rdata;
    logic                  reg_rvalid;
    logic                  err_valid;
    logic [SW-1:0]         err_space;
    logic [TW-1:0]         err_type;
    logic [32*LOG_DW-1:0]  err_hdr;
    logic                  sig_valid;
    logic                  sig_fatal;
    logic                  sig_syserr;

    modport master (
        output reg_addr, reg_wr, reg_wdata, reg_rd, err_valid, err_space, err_type, err_hdr,
        input  reg_rdata, reg_rvalid, sig_valid, sig_fatal, sig_syserr
    );

    modport slave (
        input  reg_addr, reg_wr, reg_wdata, reg_rd, err_valid, err_space, err_type, err_hdr,
        output reg_rdata, reg_rvalid, sig_valid, sig_fatal, sig_syserr
    );

endinterface

// File: rtl/rp_pio_err_regs_first_err_log.sv
// First Error Pointer, its valid flag and the header log of the first unmasked error.
module rp_pio_first_err_log #(
    parameter int unsigned LOG_DW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [4:0]           load_idx,
    input  logic [32*LOG_DW-1:0] load_hdr,
    input  logic [31:0]          clr_bits,
    output logic [4:0]           ptr,
    output logic                 ptr_valid,
    output logic [32*LOG_DW-1:0] hdr_log
);
    logic [4:0]           ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [32*LOG_DW-1:0] log_q, log_d;
    logic                 cleared;

    // A clear of the pointed-to status bit frees the pointer in the same cycle,
    // so a coincident unmasked event can claim it immediately.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        log_d   = log_q;
        cleared = valid_q && clr_bits[ptr_q];
        if (cleared) valid_d = 1'b0;
        if (load && (!valid_q || cleared)) begin
            ptr_d   = load_idx;
            valid_d = 1'b1;
            log_d   = load_hdr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            log_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            log_q   <= log_d;
        end
    end

    assign ptr       = ptr_q;
    assign ptr_valid = valid_q;
    assign hdr_log   = log_q;

endmodule

// File: rtl/rp_pio_err_regs.sv
// Root Port PIO error registers: status/mask/severity/syserr, read mux and error signalling.
// First-error pointer and header log live in rp_pio_first_err_log.
module rp_pio_err_regs
    import rp_pio_pkg::*;
#(
    parameter int unsigned NUM_SPACES   = 3,
    parameter int unsigned NUM_ERR      = 3,
    parameter int unsigned FIELD_STRIDE = 8,
    parameter int unsigned LOG_DW       = 4,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    rp_pio_err_regs_if.slave   bus
);
    localparam logic [31:0] IMPL = implemented_mask(NUM_SPACES, NUM_ERR, FIELD_STRIDE);

    if (NUM_ERR > FIELD_STRIDE) begin : g_chk_stride
        $error("NUM_ERR must not exceed FIELD_STRIDE");
    end
    if (NUM_SPACES * FIELD_STRIDE > 32) begin : g_chk_width
        $error("NUM_SPACES*FIELD_STRIDE must not exceed 32");
    end
    if (5 + LOG_DW > 2 ** ADDR_W) begin : g_chk_addr
        $error("register map does not fit in ADDR_W");
    end

    logic [31:0] status_q, status_d, mask_q, mask_d;
    logic [31:0] sev_q, sev_d, syserr_q, syserr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        sig_valid_q, sig_valid_d, sig_fatal_q, sig_fatal_d;
    logic        sig_syserr_q, sig_syserr_d;

    logic [4:0]           ev_idx;
    logic                 ev_hit, ev_unmasked;
    logic [31:0]          ev_bit, w1c_bits;
    logic [4:0]           ptr;
    logic                 ptr_valid;
    logic [32*LOG_DW-1:0] hdr_log;

    always_comb begin
        ev_idx      = 5'(32'(bus.err_space) * FIELD_STRIDE + 32'(bus.err_type));
        ev_hit      = bus.err_valid && (32'(bus.err_space) < NUM_SPACES)
                                    && (32'(bus.err_type) < NUM_ERR);
        ev_bit      = ev_hit ? (32'd1 << ev_idx) : '0;
        ev_unmasked = ev_hit && !mask_q[ev_idx];
        w1c_bits    = (bus.reg_wr && bus.reg_addr == ADDR_W'(REG_STATUS))
                      ? (bus.reg_wdata & IMPL) : '0;
    end

    // Event set is OR-ed after the W1C so a coincident set wins.
    always_comb begin
        status_d = (status_q & ~w1c_bits) | ev_bit;
        mask_d   = mask_q;
        sev_d    = sev_q;
        syserr_d = syserr_q;
        if (bus.reg_wr) begin
            if (bus.reg_addr == ADDR_W'(REG_MASK))   mask_d   = bus.reg_wdata & IMPL;
            if (bus.reg_addr == ADDR_W'(REG_SEV))    sev_d    = bus.reg_wdata & IMPL;
            if (bus.reg_addr == ADDR_W'(REG_SYSERR)) syserr_d = bus.reg_wdata & IMPL;
        end
        sig_valid_d  = ev_unmasked;
        sig_fatal_d  = ev_unmasked && sev_q[ev_idx];
        sig_syserr_d = ev_unmasked && syserr_q[ev_idx];
    end

    always_comb begin
        rvalid_d = bus.reg_rd;
        rdata_d  = rdata_q;
        if (bus.reg_rd) begin
            rdata_d = '0;
            if (bus.reg_addr == ADDR_W'(REG_STATUS))      rdata_d = status_q;
            else if (bus.reg_addr == ADDR_W'(REG_MASK))   rdata_d = mask_q;
            else if (bus.reg_addr == ADDR_W'(REG_SEV))    rdata_d = sev_q;
            else if (bus.reg_addr == ADDR_W'(REG_SYSERR)) rdata_d = syserr_q;
            else if (bus.reg_addr == ADDR_W'(REG_PTR))    rdata_d = {ptr_valid, 26'd0, ptr};
            else begin
                for (int unsigned i = 0; i < LOG_DW; i++) begin
                    if (bus.reg_addr == ADDR_W'(REG_LOG0 + i)) rdata_d = hdr_log[i*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q     <= '0;
            mask_q       <= IMPL;
            sev_q        <= '0;
            syserr_q     <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            sig_valid_q  <= 1'b0;
            sig_fatal_q  <= 1'b0;
            sig_syserr_q <= 1'b0;
        end else begin
            status_q     <= status_d;
            mask_q       <= mask_d;
            sev_q        <= sev_d;
            syserr_q     <= syserr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            sig_valid_q  <= sig_valid_d;
            sig_fatal_q  <= sig_fatal_d;
            sig_syserr_q <= sig_syserr_d;
        end
    end

    rp_pio_first_err_log #(.LOG_DW(LOG_DW)) u_first_err_log (
        .clk       (clk),
        .rst       (rst),
        .load      (ev_unmasked),
        .load_idx  (ev_idx),
        .load_hdr  (bus.err_hdr),
        .clr_bits  (w1c_bits),
        .ptr       (ptr),
        .ptr_valid (ptr_valid),
        .hdr_log   (hdr_log)
    );

    assign bus.reg_rdata  = rdata_q;
    assign bus.reg_rvalid = rvalid_q;
    assign bus.sig_valid  = sig_valid_q;
    assign bus.sig_fatal  = sig_fatal_q;
    assign bus.sig_syserr = sig_syserr_q;

endmodule
